// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access path: FSM states, requester ids,
// default data-segment base and the round-robin pick helper.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } arb_state_e;

    localparam logic        REQ_CPU        = 1'b0;
    localparam logic        REQ_LDR        = 1'b1;
    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

    // On a tie the requester that did not win last time goes first.
    function automatic logic rr_pick(input logic cpu_req, input logic ldr_req, input logic last);
        if (cpu_req && ldr_req) return ~last;
        else if (ldr_req)       return REQ_LDR;
        else                    return REQ_CPU;
    endfunction

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Requester-side port bundle (CPU / loader) and the single-port data RAM bundle.
interface dmem_port_if #(parameter int N_BITS = 32);
    logic              req;
    logic              we;
    logic [N_BITS-1:0] addr;
    logic [N_BITS-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [N_BITS-1:0] rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

interface dmem_mem_if #(parameter int N_BITS = 32, parameter int ADDR_W = 10);
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [N_BITS-1:0] wdata;
    logic [N_BITS-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_addr_xlate.sv
// MARS byte address -> RAM word index, with misalignment and range flags.
module dmem_addr_xlate
    import mips_mem_pkg::*;
#(
    parameter int                N_BITS    = 32,
    parameter logic [N_BITS-1:0] BASE_ADDR = N_BITS'(DMEM_BASE_ADDR),
    parameter int                MEM_DEPTH = 1024,
    localparam int               ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic [N_BITS-1:0] addr_i,
    output logic [ADDR_W-1:0] word_idx_o,
    output logic              misaligned_o,
    output logic              out_of_range_o
);
    logic [N_BITS-1:0] offset;

    // Addresses below the base wrap to a huge offset and fail the range check.
    assign offset         = addr_i - BASE_ADDR;
    assign word_idx_o     = offset[ADDR_W+1:2];
    assign misaligned_o   = |offset[1:0];
    assign out_of_range_o = offset[N_BITS-1:2] >= (N_BITS-2)'(MEM_DEPTH);
endmodule

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing the data RAM between CPU and loader.
// Define DMEM_ERR_CHECK_EN to reject misaligned / out-of-range requests.
module dmem_access_arbiter
    import mips_mem_pkg::*;
#(
    parameter int                N_BITS      = 32,
    parameter logic [N_BITS-1:0] BASE_ADDR   = N_BITS'(DMEM_BASE_ADDR),
    parameter int                MEM_DEPTH   = 1024,
    parameter int                MEM_LATENCY = 1,
    localparam int               ADDR_W      = $clog2(MEM_DEPTH),
    localparam int               CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic       clk,
    input  logic       reset,
    dmem_port_if.slave cpu,
    dmem_port_if.slave ldr,
    dmem_mem_if.master mem,
    output logic       busy_o
);
    arb_state_e        state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [N_BITS-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BITS-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [N_BITS-1:0] ldr_rdata_q, ldr_rdata_d;

    logic              pick;
    logic [N_BITS-1:0] req_addr;
    logic [ADDR_W-1:0] xl_idx;
    logic              xl_mis, xl_oor;
    logic              req_bad;

    assign pick     = rr_pick(cpu.req, ldr.req, last_q);
    assign req_addr = pick ? ldr.addr : cpu.addr;

    dmem_addr_xlate #(
        .N_BITS    (N_BITS),
        .BASE_ADDR (BASE_ADDR),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_xlate (
        .addr_i         (req_addr),
        .word_idx_o     (xl_idx),
        .misaligned_o   (xl_mis),
        .out_of_range_o (xl_oor)
    );

`ifdef DMEM_ERR_CHECK_EN
    assign req_bad = xl_mis | xl_oor;
`else
    logic unused_xl_flags;
    assign unused_xl_flags = xl_mis ^ xl_oor;
    assign req_bad         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        last_d      = last_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu.req || ldr.req) begin
                    winner_d = pick;
                    last_d   = pick;
                    we_d     = pick ? ldr.we : cpu.we;
                    wdata_d  = pick ? ldr.wdata : cpu.wdata;
                    idx_d    = xl_idx;
                    state_d  = req_bad ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(MEM_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // RAM data is valid in the cycle the counter reaches one.
                if (cnt_q == CNT_W'(1)) begin
                    if (winner_q == REQ_LDR) ldr_rdata_d = mem.rdata;
                    else                     cpu_rdata_d = mem.rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= REQ_CPU;
            last_q      <= REQ_LDR;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign mem.en    = (state_q == ST_ISSUE);
    assign mem.we    = (state_q == ST_ISSUE) && we_q;
    assign mem.addr  = idx_q;
    assign mem.wdata = wdata_q;

    assign cpu.gnt    = ((state_q == ST_ISSUE) || (state_q == ST_ERR)) && (winner_q == REQ_CPU);
    assign ldr.gnt    = ((state_q == ST_ISSUE) || (state_q == ST_ERR)) && (winner_q == REQ_LDR);
    assign cpu.rvalid = (state_q == ST_RESP) && (winner_q == REQ_CPU);
    assign ldr.rvalid = (state_q == ST_RESP) && (winner_q == REQ_LDR);
    assign cpu.rdata  = cpu_rdata_q;
    assign ldr.rdata  = ldr_rdata_q;

`ifdef DMEM_ERR_CHECK_EN
    assign cpu.err = (state_q == ST_ERR) && (winner_q == REQ_CPU);
    assign ldr.err = (state_q == ST_ERR) && (winner_q == REQ_LDR);
`else
    assign cpu.err = 1'b0;
    assign ldr.err = 1'b0;
`endif

    assign busy_o = (state_q != ST_IDLE);
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter with a 2-cycle-latency RAM model.
module tb_dmem_access_arbiter;
    localparam int LAT = 2;

    typedef struct {
        logic        is_rv;
        logic        id;
        int          cyc;
        logic        err;
        logic        we;
        logic [9:0]  idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic reset;
    logic busy;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    exp_t        sb[$];
    exp_t        em;
    logic [31:0] held [0:1];
    logic [31:0] mem_arr [0:1023];
    logic [31:0] rd_pipe0, rd_pipe1;

    dmem_port_if #(.N_BITS(32)) cpu_if ();
    dmem_port_if #(.N_BITS(32)) ldr_if ();
    dmem_mem_if  #(.N_BITS(32), .ADDR_W(10)) m_if ();

    dmem_access_arbiter #(
        .N_BITS      (32),
        .BASE_ADDR   (32'h1001_0000),
        .MEM_DEPTH   (1024),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .cpu    (cpu_if),
        .ldr    (ldr_if),
        .mem    (m_if),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data appears LAT cycles after the enable cycle.
    always @(posedge clk) begin
        if (m_if.en && m_if.we) mem_arr[m_if.addr] <= m_if.wdata;
        rd_pipe0 <= mem_arr[m_if.addr];
        rd_pipe1 <= rd_pipe0;
    end
    assign m_if.rdata = rd_pipe1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (cpu_if.gnt || ldr_if.gnt || cpu_if.rvalid || ldr_if.rvalid) begin
                if (sb.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_event: gnt=%b%b rvalid=%b%b, expected none",
                             cpu_if.gnt, ldr_if.gnt, cpu_if.rvalid, ldr_if.rvalid);
                end else begin
                    em = sb.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(em.cyc));
                    if (!em.is_rv) begin
                        chk("gnt_cpu", 32'(cpu_if.gnt), 32'(em.id == 1'b0));
                        chk("gnt_ldr", 32'(ldr_if.gnt), 32'(em.id == 1'b1));
                        chk("err", 32'(em.id ? ldr_if.err : cpu_if.err), 32'(em.err));
                        chk("mem_en", 32'(m_if.en), 32'(!em.err));
                        if (!em.err) begin
                            chk("mem_we", 32'(m_if.we), 32'(em.we));
                            chk("mem_addr", 32'(m_if.addr), 32'(em.idx));
                            if (em.we) chk("mem_wdata", m_if.wdata, em.wdata);
                        end
                    end else begin
                        chk("rvalid_cpu", 32'(cpu_if.rvalid), 32'(em.id == 1'b0));
                        chk("rvalid_ldr", 32'(ldr_if.rvalid), 32'(em.id == 1'b1));
                        chk("rdata", em.id ? ldr_if.rdata : cpu_if.rdata, em.rdata);
                        chk("rdata_hold", em.id ? cpu_if.rdata : ldr_if.rdata, held[~em.id]);
                        held[em.id] = em.rdata;
                    end
                end
            end else if (m_if.en) begin
                nchk++;
                nfail++;
                $display("FAIL mem_en_stray: got 1 expected 0 without a grant");
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            nchk++;
            nfail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        int   n = 0;
        logic got = 1'b0;
        if (id) begin
            ldr_if.req = 1'b1; ldr_if.we = we; ldr_if.addr = addr; ldr_if.wdata = wdata;
        end else begin
            cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
        end
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            got = id ? ldr_if.gnt : cpu_if.gnt;
        end
        if (!got) begin
            nchk++;
            nfail++;
            $display("FAIL gnt_timeout: got no grant for id %0d, expected one", id);
        end
        if (id) ldr_if.req = 1'b0;
        else    cpu_if.req = 1'b0;
    endtask

    task automatic push(input logic is_rv, input logic id, input int c, input logic err,
                        input logic we, input logic [9:0] idx, input logic [31:0] wd,
                        input logic [31:0] rd);
        sb.push_back('{is_rv: is_rv, id: id, cyc: c, err: err, we: we, idx: idx,
                       wdata: wd, rdata: rd});
    endtask

    task automatic req1(input logic id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [9:0] idx, input logic err,
                        input logic [31:0] rdata);
        wait_idle();
        push(1'b0, id, cyc + 1, err, we, idx, wdata, '0);
        if (!we && !err) push(1'b1, id, cyc + 2 + LAT, 1'b0, 1'b0, idx, '0, rdata);
        drv(id, we, addr, wdata);
    endtask

    initial begin
        reset = 1'b0;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        ldr_if.req = 1'b0; ldr_if.we = 1'b0; ldr_if.addr = '0; ldr_if.wdata = '0;
        held[0] = '0;
        held[1] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'({cpu_if.gnt, ldr_if.gnt}), 32'd0);
        chk("rst_rvalid", 32'({cpu_if.rvalid, ldr_if.rvalid}), 32'd0);
        chk("rst_mem_en", 32'({m_if.en, m_if.we}), 32'd0);
        chk("rst_mem_addr", 32'(m_if.addr), 32'd0);
        chk("rst_mem_wdata", m_if.wdata, 32'd0);
        chk("rst_rdata", cpu_if.rdata | ldr_if.rdata, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Tie straight out of reset: CPU, then LDR; second tie: CPU again.
        wait_idle();
        push(1'b0, 1'b0, cyc + 1, 1'b0, 1'b1, 10'd8, 32'h1111_1111, '0);
        push(1'b0, 1'b1, cyc + 3, 1'b0, 1'b1, 10'd9, 32'h2222_2222, '0);
        fork
            drv(1'b0, 1'b1, 32'h1001_0020, 32'h1111_1111);
            drv(1'b1, 1'b1, 32'h1001_0024, 32'h2222_2222);
        join
        wait_idle();
        push(1'b0, 1'b0, cyc + 1, 1'b0, 1'b1, 10'd10, 32'h3333_3333, '0);
        push(1'b0, 1'b1, cyc + 3, 1'b0, 1'b1, 10'd11, 32'h4444_4444, '0);
        fork
            drv(1'b0, 1'b1, 32'h1001_0028, 32'h3333_3333);
            drv(1'b1, 1'b1, 32'h1001_002C, 32'h4444_4444);
        join

        req1(1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 10'd1, 1'b0, '0);
        req1(1'b0, 1'b0, 32'h1001_0004, '0, 10'd1, 1'b0, 32'hDEAD_BEEF);
        req1(1'b1, 1'b0, 32'h1001_0024, '0, 10'd9, 1'b0, 32'h2222_2222);
        req1(1'b0, 1'b0, 32'h1001_0028, '0, 10'd10, 1'b0, 32'h3333_3333);
        req1(1'b1, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 10'd1023, 1'b0, '0);
        req1(1'b1, 1'b0, 32'h1001_0FFC, '0, 10'd1023, 1'b0, 32'hCAFE_F00D);
`ifdef DMEM_ERR_CHECK_EN
        req1(1'b0, 1'b1, 32'h1001_0002, 32'h5555_5555, 10'd0, 1'b1, '0);
        req1(1'b1, 1'b0, 32'h0FFF_FFFC, '0, 10'd0, 1'b1, '0);
        req1(1'b0, 1'b0, 32'h1001_1000, '0, 10'd0, 1'b1, '0);
`else
        req1(1'b0, 1'b1, 32'h1001_1000, 32'hA5A5_A5A5, 10'd0, 1'b0, '0);
        req1(1'b1, 1'b0, 32'h1001_0000, '0, 10'd0, 1'b0, 32'hA5A5_A5A5);
`endif

        // Reset while the read sits in WAIT: grant seen, no rvalid afterwards.
        wait_idle();
        push(1'b0, 1'b0, cyc + 1, 1'b0, 1'b0, 10'd1, '0, '0);
        drv(1'b0, 1'b0, 32'h1001_0004, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rvalid", 32'(cpu_if.rvalid), 32'd0);
        chk("midrst_rdata", cpu_if.rdata, 32'd0);
        held[0] = '0;
        held[1] = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        req1(1'b0, 1'b0, 32'h1001_0004, '0, 10'd1, 1'b0, 32'hDEAD_BEEF);

        wait_idle();
        repeat (4) @(posedge clk);
        chk("end_idle", 32'(busy), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
